square_sum_pipe: RTL

- Pipelined inverse of the root-sum datapath: computes res = ra^2 + rb^2 + rc^2 for three unsigned roots.
- Accepts one argument set per clock and returns one result per clock at a fixed latency. There is no backpressure.
- Used as the reference model and back-check partner of the isqrt-based root-sum pipelines: feeding it isqrt outputs should reconstruct values bounded by the original arguments.
- Valid bits gate every data register to save dynamic power.

---
 rtl/square_sum_if.sv | 22 ++
 rtl/square_sum_pipe.sv | 100 ++++++++++
 2 files changed

// File: rtl/square_sum_if.sv
// Argument/result bundle for the square-sum pipeline.
// master drives roots, slave returns the summed squares.
interface square_sum_if #(
  parameter int W = 16
);
  logic             arg_vld;
  logic [W-1:0]     ra;
  logic [W-1:0]     rb;
  logic [W-1:0]     rc;
  logic             res_vld;
  logic [2*W+1:0]   res;

  modport master (
    output arg_vld, ra, rb, rc,
    input  res_vld, res
  );

  modport slave (
    input  arg_vld, ra, rb, rc,
    output res_vld, res
  );
endinterface

// File: rtl/square_sum_pipe.sv
// Pipelined ra^2 + rb^2 + rc^2 using shift-add squaring stages.
// Input register, STAGES squaring stages, then one summation stage.
module square_sum_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 4
) (
  input  logic      clk,
  input  logic      rst,
  square_sum_if.slave bus
);
  localparam int SEG = W / STAGES;
  localparam int PW  = 2 * W;
  localparam int RW  = 2 * W + 2;

  logic [STAGES:0] vld_q;
  logic [STAGES:0] vld_d;
  logic            res_vld_q;
  logic            res_vld_d;
  logic [RW-1:0]   res_q;
  logic [RW-1:0]   res_d;

  logic [W-1:0]  x_q [STAGES][3];
  logic [W-1:0]  x_d [STAGES][3];
  logic [PW-1:0] p_q [STAGES][3];
  logic [PW-1:0] p_d [STAGES][3];
  logic [PW-1:0] p_in [STAGES][3];

  always_comb begin
    vld_d     = {vld_q[STAGES-1:0], bus.arg_vld};
    res_vld_d = vld_q[STAGES];
    x_d       = x_q;
    p_d       = p_q;
    res_d     = res_q;

    for (int c = 0; c < 3; c++) begin
      p_in[0][c] = '0;
    end
    for (int k = 1; k < STAGES; k++) begin
      for (int c = 0; c < 3; c++) begin
        p_in[k][c] = p_q[k-1][c];
      end
    end

    if (bus.arg_vld) begin
      x_d[0][0] = bus.ra;
      x_d[0][1] = bus.rb;
      x_d[0][2] = bus.rc;
    end

    // Operand rides along so each stage can add its slice of shifts.
    for (int k = 1; k < STAGES; k++) begin
      if (vld_q[k-1]) begin
        for (int c = 0; c < 3; c++) begin
          x_d[k][c] = x_q[k-1][c];
        end
      end
    end

    for (int k = 0; k < STAGES; k++) begin
      if (vld_q[k]) begin
        for (int c = 0; c < 3; c++) begin
          p_d[k][c] = p_in[k][c];
          for (int j = 0; j < SEG; j++) begin
            if (x_q[k][c][k*SEG+j]) begin
              p_d[k][c] = p_d[k][c]
                + (PW'(x_q[k][c]) << (k*SEG+j));
            end
          end
        end
      end
    end

    if (vld_q[STAGES]) begin
      res_d = RW'(p_q[STAGES-1][0])
            + RW'(p_q[STAGES-1][1])
            + RW'(p_q[STAGES-1][2]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q     <= '0;
      res_vld_q <= 1'b0;
      res_q     <= '0;
    end else begin
      vld_q     <= vld_d;
      res_vld_q <= res_vld_d;
      res_q     <= res_d;
    end
  end

  // Datapath flops hold unless their valid loads them.
  always_ff @(posedge clk) begin
    x_q <= x_d;
    p_q <= p_d;
  end

  assign bus.res_vld = res_vld_q;
  assign bus.res     = res_q;
endmodule
